// File: rtl/core_boot_sequencer.sv
// Reset/boot sequencer for a cluster of cores: programmable reset hold, staggered
// per-core release, per-core boot address and halt with a bounded drain.

module core_boot_lane #(
   parameter logic [31:0] OFFSET = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load,
   input  logic [31:0] base,
   output logic [31:0] boot_addr
);
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i)     boot_addr <= '0;
      else if (load) boot_addr <= base + OFFSET;
endmodule

module core_boot_sequencer #(
   parameter int          N_CORES         = 8,
   parameter int          RST_HOLD_CYCLES = 2,
   parameter int          STAGGER_CYCLES  = 4,
   parameter int          DRAIN_TIMEOUT   = 255,
   parameter logic [31:0] BOOT_STRIDE     = 32'h100
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       halt_req_i,
   input  logic [31:0]                boot_addr_i,
   input  logic [N_CORES-1:0]         core_busy_i,
   output logic [N_CORES-1:0]         core_rst_no,
   output logic [N_CORES-1:0]         fetch_enable_o,
   output logic [N_CORES-1:0][31:0]   boot_addr_o,
   output logic [2:0]                 state_o,
   output logic                       done_o,
   output logic [N_CORES-1:0]         timeout_o
);
   typedef enum logic [2:0] {IDLE = 3'd0, HOLD = 3'd1, STAGGER = 3'd2, RUN = 3'd3, DRAIN = 3'd4} state_t;

   localparam int HW    = (RST_HOLD_CYCLES > 0) ? $clog2(RST_HOLD_CYCLES + 1) : 1;
   localparam int SW    = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;
   localparam int DW    = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
   localparam int IW    = $clog2(N_CORES + 1);
   localparam int SLOAD = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;

   state_t             state, state_nxt;
   logic [N_CORES-1:0] rel, rel_nxt, fetch_nxt, timeout_nxt;
   logic [HW-1:0]      hold_cnt, hold_nxt;
   logic [SW-1:0]      stg_cnt, stg_nxt;
   logic [IW-1:0]      idx, idx_nxt;
   logic [DW-1:0]      drain_cnt, drain_nxt;
   logic               done_nxt, load;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         rel            <= '0;
         hold_cnt       <= '0;
         stg_cnt        <= '0;
         idx            <= '0;
         drain_cnt      <= '0;
         fetch_enable_o <= '0;
         done_o         <= 1'b0;
         timeout_o      <= '0;
      end else begin
         state          <= state_nxt;
         rel            <= rel_nxt;
         hold_cnt       <= hold_nxt;
         stg_cnt        <= stg_nxt;
         idx            <= idx_nxt;
         drain_cnt      <= drain_nxt;
         fetch_enable_o <= fetch_nxt;
         done_o         <= done_nxt;
         timeout_o      <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      rel_nxt     = rel;
      hold_nxt    = hold_cnt;
      stg_nxt     = stg_cnt;
      idx_nxt     = idx;
      drain_nxt   = drain_cnt;
      done_nxt    = 1'b0;
      timeout_nxt = timeout_o;
      load        = 1'b0;
      case (state)
         IDLE: begin
            rel_nxt = '0;
            if (start_i) begin
               load        = 1'b1;
               timeout_nxt = '0;
               hold_nxt    = HW'(RST_HOLD_CYCLES - 1);
               state_nxt   = HOLD;
            end
         end
         HOLD: begin
            if (halt_req_i) begin
               state_nxt = DRAIN;
               drain_nxt = DW'(DRAIN_TIMEOUT);
            end else if (hold_cnt == '0) begin
               state_nxt = STAGGER;
               stg_nxt   = SW'(SLOAD);
               if (STAGGER_CYCLES == 0) begin
                  rel_nxt = '1;
                  idx_nxt = IW'(N_CORES);
               end else begin
                  rel_nxt[0] = 1'b1;
                  idx_nxt    = IW'(1);
               end
            end else begin
               hold_nxt = hold_cnt - 1'b1;
            end
         end
         STAGGER: begin
            // halt wins over a release due on the same edge
            if (halt_req_i) begin
               state_nxt = DRAIN;
               drain_nxt = DW'(DRAIN_TIMEOUT);
            end else if (idx == IW'(N_CORES)) begin
               state_nxt = RUN;
            end else if (stg_cnt == '0) begin
               rel_nxt = rel | (N_CORES'(1) << idx);
               idx_nxt = idx + 1'b1;
               stg_nxt = SW'(SLOAD);
            end else begin
               stg_nxt = stg_cnt - 1'b1;
            end
         end
         RUN: begin
            if (halt_req_i) begin
               state_nxt = DRAIN;
               drain_nxt = DW'(DRAIN_TIMEOUT);
            end
         end
         DRAIN: begin
            // busy-clear is checked first so it wins a tie with expiry
            if ((core_busy_i & rel) == '0) begin
               state_nxt   = IDLE;
               rel_nxt     = '0;
               done_nxt    = 1'b1;
               timeout_nxt = '0;
            end else if (drain_cnt <= DW'(1)) begin
               state_nxt   = IDLE;
               rel_nxt     = '0;
               done_nxt    = 1'b1;
               timeout_nxt = core_busy_i & rel;
            end else begin
               drain_nxt = drain_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            rel_nxt   = '0;
         end
      endcase
      fetch_nxt = (state_nxt == HOLD || state_nxt == STAGGER || state_nxt == RUN) ? rel_nxt : '0;
   end

   assign core_rst_no = rel;
   assign state_o     = state;

   for (genvar k = 0; k < N_CORES; k++) begin : g_lane
      core_boot_lane #(.OFFSET(BOOT_STRIDE * 32'(k))) u_lane (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .load      (load),
         .base      (boot_addr_i),
         .boot_addr (boot_addr_o[k])
      );
   end
endmodule
